fl_retire_buf: RTL and testbench

FL_RETIRE_BUF -- requirements
Module: fl_retire_buf

---
 rtl/fl_retire_buf_if.sv | 44 ++++
 rtl/fl_retire_buf.sv | 142 ++++++++++++++
 tb/tb_fl_retire_buf.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fl_retire_buf_if.sv
// -----------------------------------------------------------------------------
// fl_retire_buf_if
// Bundles the ROB-side retire slots and the free-list-side return port of the
// retire buffer.
//   rt0_en_i / rt0_preg_i   : retire slot 0 (older) valid and freed preg
//   rt1_en_i / rt1_preg_i   : retire slot 1 (younger) valid and freed preg
//   stall_o                 : fewer than two free entries, back to the ROB
//   retire_en_o / _preg_o   : one preg returned to the free list this cycle
//   cnt_o                   : current occupancy
//   ovf_o                   : sticky overflow flag
// Modports: master = ROB / free-list side (testbench), slave = fl_retire_buf.
// Also provides default values for `PRF_IDX_W and `ZERO_REG if the including
// build has not defined them.
// -----------------------------------------------------------------------------
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ZERO_REG
`define ZERO_REG 31
`endif

interface fl_retire_buf_if #(
    parameter int DEPTH = 8
);
    logic                      rt0_en_i;
    logic [`PRF_IDX_W-1:0]     rt0_preg_i;
    logic                      rt1_en_i;
    logic [`PRF_IDX_W-1:0]     rt1_preg_i;
    logic                      stall_o;
    logic                      retire_en_o;
    logic [`PRF_IDX_W-1:0]     retire_preg_o;
    logic [$clog2(DEPTH):0]    cnt_o;
    logic                      ovf_o;

    modport master (
        output rt0_en_i, rt0_preg_i, rt1_en_i, rt1_preg_i,
        input  stall_o, retire_en_o, retire_preg_o, cnt_o, ovf_o
    );

    modport slave (
        input  rt0_en_i, rt0_preg_i, rt1_en_i, rt1_preg_i,
        output stall_o, retire_en_o, retire_preg_o, cnt_o, ovf_o
    );
endinterface

// File: rtl/fl_retire_buf.sv
// -----------------------------------------------------------------------------
// fl_retire_buf
// Small FIFO between the two-wide ROB retire port and the one-wide free-list
// return port. Freed (told) pregs from up to two retiring instructions per
// cycle are enqueued in age order; one preg per cycle is handed back to the
// free list with no back-pressure. Slots carrying `ZERO_REG are discarded.
// Ports:
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset (clears pointers and ovf)
//   rb    : fl_retire_buf_if.slave (retire slots in, free-list return out,
//           stall/occupancy/overflow status)
// Optional feature macro: FL_RB_BYPASS_EN -- when defined and the buffer is
// empty, the first accepted slot is returned combinationally in the same cycle
// and only the remaining slot is enqueued.
// -----------------------------------------------------------------------------
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ZERO_REG
`define ZERO_REG 31
`endif

module fl_retire_buf #(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    fl_retire_buf_if.slave     rb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = `PRF_IDX_W;
    localparam logic [PW-1:0] ZREG    = PW'(`ZERO_REG);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Entry storage carries no reset; validity comes from the pointers.
    logic [PW-1:0] mem_q [DEPTH];

    // Pointers: MSB is the wrap bit, low AW bits index the storage.
    logic [AW:0]   head_q, head_d;
    logic [AW:0]   tail_q, tail_d;
    logic          ovf_q, ovf_d;

    logic [CW-1:0] cnt;
    logic          empty, full;
    logic          acc0, acc1;
    logic          drain, byp;
    logic [PW-1:0] byp_preg;
    logic [PW-1:0] enq0_preg, enq1_preg;
    logic [1:0]    n_enq, n_store;
    logic [CW-1:0] free_after;
    logic          we0, we1;
    logic [AW-1:0] waddr0, waddr1;

    assign cnt   = tail_q - head_q;
    assign empty = (head_q == tail_q);
    assign full  = (head_q[AW-1:0] == tail_q[AW-1:0]) && (head_q[AW] != tail_q[AW]);

    always_comb begin
        acc0       = 1'b0;
        acc1       = 1'b0;
        drain      = 1'b0;
        byp        = 1'b0;
        byp_preg   = ZREG;
        enq0_preg  = ZREG;
        enq1_preg  = ZREG;
        n_enq      = 2'd0;
        n_store    = 2'd0;
        free_after = '0;
        ovf_d      = ovf_q;
        head_d     = head_q;
        tail_d     = tail_q;
        we0        = 1'b0;
        we1        = 1'b0;
        waddr0     = tail_q[AW-1:0];
        waddr1     = tail_q[AW-1:0] + AW'(1);

        // Gating with rst keeps the bypass path quiet while reset is held.
        acc0  = !rst && rb.rt0_en_i && (rb.rt0_preg_i != ZREG);
        acc1  = !rst && rb.rt1_en_i && (rb.rt1_preg_i != ZREG);
        drain = !empty;

`ifdef FL_RB_BYPASS_EN
        if (empty && (acc0 || acc1)) begin
            byp      = 1'b1;
            byp_preg = acc0 ? rb.rt0_preg_i : rb.rt1_preg_i;
        end
`endif

        // Compact the surviving slots so the oldest always lands at the tail.
        if (byp) begin
            n_enq     = {1'b0, acc0 && acc1};
            enq0_preg = rb.rt1_preg_i;
        end else if (acc0 && acc1) begin
            n_enq     = 2'd2;
            enq0_preg = rb.rt0_preg_i;
            enq1_preg = rb.rt1_preg_i;
        end else if (acc0 || acc1) begin
            n_enq     = 2'd1;
            enq0_preg = acc0 ? rb.rt0_preg_i : rb.rt1_preg_i;
        end

        // Space freed by this cycle's drain is reusable in the same edge.
        free_after = DEPTH_C - cnt + {{(CW-1){1'b0}}, drain};
        if ({{(CW-2){1'b0}}, n_enq} > free_after) begin
            n_store = free_after[1:0];
            ovf_d   = 1'b1;
        end else begin
            n_store = n_enq;
        end

        we0    = (n_store != 2'd0);
        we1    = (n_store == 2'd2);
        head_d = head_q + {{AW{1'b0}}, drain};
        tail_d = tail_q + {{(AW-1){1'b0}}, n_store};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we0) mem_q[waddr0] <= enq0_preg;
        if (we1) mem_q[waddr1] <= enq1_preg;
    end

    assign rb.retire_en_o   = drain || byp;
    assign rb.retire_preg_o = drain ? mem_q[head_q[AW-1:0]] : (byp ? byp_preg : ZREG);
    assign rb.cnt_o         = cnt;
    assign rb.ovf_o         = ovf_q;
    // (DEPTH - cnt) < 2 is exactly "full or one slot left".
    assign rb.stall_o       = full || (cnt == DEPTH_C - CW'(1));

endmodule

// File: tb/tb_fl_retire_buf.sv
// -----------------------------------------------------------------------------
// tb_fl_retire_buf
// Directed bench for fl_retire_buf (DEPTH=8). Inputs change 1 ns after the
// rising edge; outputs are sampled there too, well away from the next edge.
// -----------------------------------------------------------------------------
`ifndef PRF_IDX_W
`define PRF_IDX_W 6
`endif
`ifndef ZERO_REG
`define ZERO_REG 31
`endif

module tb_fl_retire_buf;
    localparam int DEPTH = 8;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fl_retire_buf_if #(.DEPTH(DEPTH)) rb ();

    fl_retire_buf #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .rb  (rb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic e0, input int p0, input logic e1, input int p1);
        rb.rt0_en_i   = e0;
        rb.rt0_preg_i = p0[`PRF_IDX_W-1:0];
        rb.rt1_en_i   = e1;
        rb.rt1_preg_i = p1[`PRF_IDX_W-1:0];
    endtask

    task automatic chk_out(input string tag, input logic en, input int preg, input int cnt);
        chk({tag, ".en"},   32'(rb.retire_en_o),   32'(en));
        chk({tag, ".preg"}, 32'(rb.retire_preg_o), 32'(preg));
        chk({tag, ".cnt"},  32'(rb.cnt_o),         32'(cnt));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive(1'b0, 0, 1'b0, 0);
        #1;
        chk_out("reset", 1'b0, 31, 0);
        chk("reset.stall", 32'(rb.stall_o), 32'd0);
        chk("reset.ovf",   32'(rb.ovf_o),   32'd0);
        step();
        step();
        rst = 1'b0;

`ifdef FL_RB_BYPASS_EN
        // Empty buffer: the slot is returned in the same cycle, never counted.
        drive(1'b1, 33, 1'b0, 0);
        #1;
        chk_out("byp_single", 1'b1, 33, 0);
        step();
        drive(1'b0, 0, 1'b0, 0);
        #1;
        chk_out("byp_single_after", 1'b0, 31, 0);
        // Dual slot into empty buffer: 34 bypassed, 35 buffered.
        drive(1'b1, 34, 1'b1, 35);
        #1;
        chk_out("byp_dual", 1'b1, 34, 0);
        step();
        drive(1'b0, 0, 1'b0, 0);
        #1;
        chk_out("byp_dual_next", 1'b1, 35, 1);
        step();
        chk_out("byp_dual_empty", 1'b0, 31, 0);
`else
        // Single push, one cycle latency then drained.
        drive(1'b1, 40, 1'b0, 0);
        step();
        drive(1'b0, 0, 1'b0, 0);
        chk_out("single", 1'b1, 40, 1);
        step();
        chk_out("single_drained", 1'b0, 31, 0);

        // Dual push (12,13) three cycles in a row: +2, +1, +1 then drain.
        drive(1'b1, 12, 1'b1, 13);
        step();
        chk_out("dual1", 1'b1, 12, 2);
        step();
        chk_out("dual2", 1'b1, 13, 3);
        step();
        drive(1'b0, 0, 1'b0, 0);
        chk_out("dual3", 1'b1, 12, 4);
        chk("dual3.stall", 32'(rb.stall_o), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("dual_drain", 1'b1, (k % 2 == 0) ? 13 : 12, 3 - k);
            chk("dual_drain.stall", 32'(rb.stall_o), 32'd0);
        end
        step();
        chk_out("dual_empty", 1'b0, 31, 0);

        // ZERO_REG in slot 0 is discarded; slot 1 still enqueued.
        drive(1'b1, 31, 1'b1, 20);
        step();
        drive(1'b0, 0, 1'b0, 0);
        chk_out("zero_slot", 1'b1, 20, 1);
        step();
        chk_out("zero_slot_after", 1'b0, 31, 0);

        // Fill: pairs (1,2)..(11,12) reach cnt=7 holding 6..12.
        for (int k = 1; k <= 6; k++) begin
            drive(1'b1, 2 * k - 1, 1'b1, 2 * k);
            step();
            chk("fill.cnt", 32'(rb.cnt_o), 32'(k + 1));
            chk("fill.stall", 32'(rb.stall_o), (k + 1 >= 7) ? 32'd1 : 32'd0);
        end
        chk("fill.ovf", 32'(rb.ovf_o), 32'd0);
        // cnt 7 + 2 - 1 = 8: still fits.
        drive(1'b1, 13, 1'b1, 14);
        step();
        chk_out("full", 1'b1, 7, 8);
        chk("full.ovf", 32'(rb.ovf_o), 32'd0);
        // cnt 8, one slot freed by the drain: 15 stored, 16 dropped.
        drive(1'b1, 15, 1'b1, 16);
        step();
        drive(1'b0, 0, 1'b0, 0);
        chk_out("ovf", 1'b1, 8, 8);
        chk("ovf.flag", 32'(rb.ovf_o), 32'd1);
        for (int v = 9; v <= 15; v++) begin
            step();
            chk("ovf_drain.preg", 32'(rb.retire_preg_o), 32'(v));
        end
        step();
        chk_out("ovf_empty", 1'b0, 31, 0);
        chk("ovf_sticky", 32'(rb.ovf_o), 32'd1);

        // Eleven pushes across the pointer wrap, draining every cycle.
        for (int k = 1; k <= 11; k++) begin
            if (k <= 5)      drive(1'b1, 2 * k - 1, 1'b1, 2 * k);
            else if (k == 6) drive(1'b1, 11, 1'b0, 0);
            else             drive(1'b0, 0, 1'b0, 0);
            step();
            chk("wrap.preg", 32'(rb.retire_preg_o), 32'(k));
            chk("wrap.en", 32'(rb.retire_en_o), 32'd1);
        end
        drive(1'b0, 0, 1'b0, 0);
        step();
        chk_out("wrap_empty", 1'b0, 31, 0);

        // Build cnt=4, then pulse rst between edges.
        drive(1'b1, 21, 1'b1, 22);
        step();
        step();
        step();
        drive(1'b0, 0, 1'b0, 0);
        chk("pre_rst.cnt", 32'(rb.cnt_o), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, 31, 0);
        chk("async_rst.stall", 32'(rb.stall_o), 32'd0);
        chk("async_rst.ovf",   32'(rb.ovf_o),   32'd0);
        #1;
        rst = 1'b0;
        drive(1'b1, 50, 1'b0, 0);
        step();
        drive(1'b0, 0, 1'b0, 0);
        chk_out("post_rst", 1'b1, 50, 1);
        step();
        chk_out("post_rst_empty", 1'b0, 31, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
